// File: rtl/binary_activation_packer.sv
// Binarizes channel-parallel signed activations and re-serializes them into OUT_SIZE-bit chunks.
// Optional: define BINARY_ACTIVATION_PACKER_THRESHOLD_EN to compare against parameter THRESHOLD instead of 0.
module binary_activation_packer #(
   parameter int IN_WIDTH = 7,
   parameter int IN_SIZE  = 4,
   parameter int OUT_SIZE = 2
`ifdef BINARY_ACTIVATION_PACKER_THRESHOLD_EN
   ,
   parameter logic signed [IN_WIDTH-1:0] THRESHOLD = {IN_WIDTH{1'b0}}
`endif
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_in,
   input  logic                              data_in_valid,
   output logic                              data_in_ready,
   output logic [OUT_SIZE-1:0]               data_out,
   output logic                              data_out_valid,
   input  logic                              data_out_ready
);

   localparam int RATIO = IN_SIZE / OUT_SIZE;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   if ((IN_SIZE % OUT_SIZE) != 0) begin : g_bad_ratio
      $error("binary_activation_packer: IN_SIZE must be a multiple of OUT_SIZE");
   end

   logic [IN_SIZE-1:0]  bits_r;
   logic                full_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [IN_SIZE-1:0]  bin_s;
   logic [OUT_SIZE-1:0] chunk_s;
   logic                last_s;
   logic                in_hs_s;
   logic                out_hs_s;

   // Per-channel binarization: 1 encodes +1, 0 encodes -1 (zero counts as +1).
   for (genvar c = 0; c < IN_SIZE; c++) begin : g_bin
`ifdef BINARY_ACTIVATION_PACKER_THRESHOLD_EN
      assign bin_s[c] = ($signed(data_in[c]) >= THRESHOLD);
`else
      assign bin_s[c] = ~data_in[c][IN_WIDTH-1];
`endif
   end

   assign last_s        = full_r && (cnt_r == CNT_W'(RATIO - 1));
   assign data_in_ready = !full_r || (last_s && data_out_ready);
   assign in_hs_s       = data_in_valid && data_in_ready;
   assign out_hs_s      = full_r && data_out_ready;

   // Chunk select as an AND-OR mux over the registered bits; no path from data_in.
   always_comb begin
      chunk_s = {OUT_SIZE{1'b0}};
      for (int k = 0; k < RATIO; k++) begin
         chunk_s = chunk_s | ({OUT_SIZE{cnt_r == CNT_W'(k)}} & bits_r[k*OUT_SIZE +: OUT_SIZE]);
      end
   end

   assign data_out       = chunk_s;
   assign data_out_valid = full_r;

   // Buffer state: a reload on the last chunk keeps full_r set so the stream has no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         bits_r <= '0;
         full_r <= 1'b0;
         cnt_r  <= '0;
      end else if (in_hs_s) begin
         bits_r <= bin_s;
         full_r <= 1'b1;
         cnt_r  <= '0;
      end else if (out_hs_s) begin
         if (last_s) begin
            full_r <= 1'b0;
            cnt_r  <= '0;
         end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/binary_activation_packer.md
Name: binary_activation_packer

Overview:
- Producer side of the binary-activation input stream feeding the next binary convolution layer.
- Takes the signed, channel-parallel uncast output of a binary convolution/linear engine (IN_SIZE channels per beat), binarizes each value (sign → 1 bit, 1 = +1, 0 = -1) and re-serializes into OUT_SIZE-bit beats in the channel-fold format that the next layer's sliding-window input expects.
- Registered, one-entry buffer with full-throughput valid/ready on both sides.

Parameters:
IN_WIDTH, 7, bit width of each signed input value (two's complement).
IN_SIZE, 4, input channels per input beat.
OUT_SIZE, 2, 1-bit channels per output beat; IN_SIZE % OUT_SIZE must be 0 (elaboration error otherwise).
RATIO, IN_SIZE/OUT_SIZE, derived localparam: output beats per input beat.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
data_in  input  IN_WIDTH x [IN_SIZE]  signed pre-activation values, array index = channel.
data_in_valid  input  1  upstream valid.
data_in_ready  output  1  upstream ready.
data_out  output  1 x [OUT_SIZE]  binarized channels of current chunk.
data_out_valid  output  1  downstream valid.
data_out_ready  input  1  downstream ready.

Behaviour:
- Binarize: bit[c] = (data_in[c] as signed >= 0) ? 1 : 0. Zero maps to 1 (+1). Bits are captured into a register bits_q[IN_SIZE-1:0] on input handshake.
- Chunk k (0..RATIO-1) = bits_q[k*OUT_SIZE +: OUT_SIZE]; data_out[j] = bits_q[k*OUT_SIZE + j]. Chunk 0 is emitted first.
- State: full_q (buffer holds data), cnt_q (current chunk, width max(1,$clog2(RATIO))).
- data_out_valid = full_q. data_out driven from bits_q/cnt_q combinationally (registered source, no comb path from data_in).
- last = full_q && (cnt_q == RATIO-1).
- data_in_ready = !full_q || (last && data_out_ready). No combinational dependence on data_in_valid.
- Output handshake (valid && ready): if not last, cnt_q++; if last, cnt_q ← 0 and full_q ← 0 unless a simultaneous input handshake occurs.
- Input handshake: bits_q ← binarized data_in, full_q ← 1, cnt_q ← 0. Simultaneous last-output and input handshake in same cycle: buffer reloaded, full_q stays 1, no bubble.
- Latency: input accepted at edge N → chunk 0 valid in cycle N+1. Sustained throughput: one output beat per cycle, one input beat per RATIO cycles.
- Backpressure: data_out_ready low holds data_out, cnt_q and bits_q stable; valid never drops without handshake.
- RATIO == 1: degenerates to a one-stage registered pipeline with full throughput (cnt_q constant 0).
- Reset: full_q=0, cnt_q=0, bits_q=0 → data_out_valid=0, data_out all 0, data_in_ready=1 in the first cycle after reset. Reset mid-stream discards the partially sent beat; no remaining chunks emitted.
- Inputs ignored while data_in_ready=0; no data loss or duplication.

Optional Feature:
- Macro BINARY_ACTIVATION_PACKER_THRESHOLD_EN.
- Defined: adds parameter THRESHOLD (signed, IN_WIDTH bits, default 0). Binarization becomes bit[c] = (data_in[c] >= THRESHOLD) ? 1 : 0, with a signed comparison. This supports folded batch-norm thresholds.
- Undefined: the threshold is fixed at 0 as above. The parameter does not exist and there is no comparator logic beyond the sign bit (bit[c] = ~data_in[c][IN_WIDTH-1]).

Test Plan:
- Reset: assert rst 2 cycles with data_in_valid=1 → data_out_valid=0, data_out=0, data_in_ready=1 on the first cycle after deassert.
- Binarize/order: data_in={ch0=5, ch1=-1, ch2=0, ch3=-64}, out_ready=1 → beat0 data_out={1,0}, beat1 data_out={1,0} on consecutive cycles; data_in_ready=1 during beat1.
- Back-to-back throughput: 8 random input beats with valid and out_ready held high → 16 output beats in 16 consecutive cycles, no bubbles, bits match the sign model.
- Backpressure: out_ready=0 for 5 cycles mid-beat (cnt_q=1) → data_out stable, data_in_ready=0, no new input accepted; after release the remaining chunk is emitted once.
- Reset mid-operation: rst after chunk 0 accepted → chunk 1 never appears; the next input's chunk 0 is the first output after reset.
- With BINARY_ACTIVATION_PACKER_THRESHOLD_EN, THRESHOLD=3: inputs {3,2,-4,63} → beats {1,0},{0,1}; without the macro, same inputs → {1,1},{0,1}.
